// File: rtl/hopfield_recall_ctrl.sv
// Recall sequencer for the Hopfield datapath: accepts a probe, clears the network,
// runs it until convergence or timeout and hands the settled state back to the host.
module hopfield_recall_ctrl #(
  parameter int N          = 9,
  parameter int SIZE       = 32,
  parameter int CLR_CYCLES = 2,
  parameter int MAX_CYCLES = 1000,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic [SIZE*N-1:0]   s_in,
  input  logic                abort,
  output logic                net_en,
  output logic                net_rst_n,
  output logic [SIZE*N-1:0]   net_s,
  input  logic [SIZE*N-1:0]   net_fullres,
  input  logic                net_done,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [SIZE*N-1:0]   res_s,
  output logic                res_converged,
  output logic [CNT_W-1:0]    res_cycles,
  output logic                busy
);

  localparam int W = SIZE * N;
  localparam logic [CNT_W-1:0] CLR_LOAD = CNT_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] clr_q, clr_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] res_cyc_q, res_cyc_d;
  logic [W-1:0]     pat_q, pat_d;
  logic [W-1:0]     res_s_q, res_s_d;
  logic             conv_q, conv_d;
  logic             sync1_q, sync2_q;
  logic             start_ready_q, busy_q, net_en_q, net_rst_n_q, res_valid_q;

  // Next-state, counter and result-capture logic.
  always_comb begin
    state_d   = state_q;
    clr_d     = clr_q;
    cyc_d     = cyc_q;
    pat_d     = pat_q;
    res_s_d   = res_s_q;
    conv_d    = conv_q;
    res_cyc_d = res_cyc_q;
    case (state_q)
      S_IDLE: begin
        if (start_valid && start_ready_q) begin
          pat_d   = s_in;
          clr_d   = CLR_LOAD;
          state_d = S_CLEAR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (clr_q == CNT_ZERO) begin
          cyc_d   = CNT_ZERO;
          state_d = S_RUN;
        end else begin
          clr_d = clr_q - CNT_ONE;
        end
      end
      S_RUN: begin
        // Abort beats a capture; a synced done beats the timeout.
        if (abort) begin
          state_d = S_IDLE;
        end else if (sync2_q || (cyc_q == MAX_CNT)) begin
          res_s_d   = net_fullres;
          conv_d    = sync2_q;
          res_cyc_d = cyc_q;
          state_d   = S_DONE;
        end else begin
          cyc_d = cyc_q + CNT_ONE;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters, pattern and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      clr_q     <= CNT_ZERO;
      cyc_q     <= CNT_ZERO;
      res_cyc_q <= CNT_ZERO;
      pat_q     <= {W{1'b0}};
      res_s_q   <= {W{1'b0}};
      conv_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_q     <= clr_d;
      cyc_q     <= cyc_d;
      res_cyc_q <= res_cyc_d;
      pat_q     <= pat_d;
      res_s_q   <= res_s_d;
      conv_q    <= conv_d;
    end
  end

  // net_done comes from another clock edge, so it only samples while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else if ((state_q == S_RUN) && !abort) begin
      sync1_q <= net_done;
      sync2_q <= sync1_q;
    end else begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end
  end

  // Status outputs decoded from the next state so they are flops, not gates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_ready_q <= 1'b1;
      busy_q        <= 1'b0;
      net_en_q      <= 1'b0;
      net_rst_n_q   <= 1'b0;
      res_valid_q   <= 1'b0;
    end else begin
      start_ready_q <= (state_d == S_IDLE);
      busy_q        <= (state_d != S_IDLE);
      net_en_q      <= (state_d == S_RUN);
      net_rst_n_q   <= (state_d == S_RUN) || (state_d == S_DONE);
      res_valid_q   <= (state_d == S_DONE);
    end
  end

  assign start_ready   = start_ready_q;
  assign busy          = busy_q;
  assign net_en        = net_en_q;
  assign net_rst_n     = net_rst_n_q;
  assign res_valid     = res_valid_q;
  assign net_s         = pat_q;
  assign res_s         = res_s_q;
  assign res_converged = conv_q;
  assign res_cycles    = res_cyc_q;

endmodule

// File: tb/tb_hopfield_recall_ctrl.sv
// Directed bench for hopfield_recall_ctrl: a timestamp-based recall model is compared
// against the DUT every cycle, with hand-computed results pinning each scenario.
module tb_hopfield_recall_ctrl;

  localparam int N = 9;
  localparam int SIZE = 32;
  localparam int W = N * SIZE;
  localparam int CLR = 2;
  localparam int MAXC = 20;
  localparam int CNT_W = 16;
  localparam int P_IDLE = 0, P_CLEAR = 1, P_RUN = 2, P_DONE = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start_valid, start_ready, abort, net_en, net_rst_n, net_done;
  logic res_valid, res_ready, res_converged, busy;
  logic [W-1:0] s_in, net_s, net_fullres, res_s;
  logic [CNT_W-1:0] res_cycles;

  hopfield_recall_ctrl #(
    .N(N), .SIZE(SIZE), .CLR_CYCLES(CLR), .MAX_CYCLES(MAXC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .s_in(s_in), .abort(abort), .net_en(net_en), .net_rst_n(net_rst_n), .net_s(net_s),
    .net_fullres(net_fullres), .net_done(net_done), .res_valid(res_valid),
    .res_ready(res_ready), .res_s(res_s), .res_converged(res_converged),
    .res_cycles(res_cycles), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_tot = 0;
  // Model: edge timestamps of the current transaction; period p is the time after edge p.
  int ecyc = 0, hs_e = -1, ab_e = -1, cap_e = -1, ack_e = -1;
  logic [W-1:0] m_pat, m_rs;
  logic m_conv, d1, d2;
  int m_rc;
  int run_i = 0, done_at = 0;
  logic [W-1:0] pa, pb, pc, pd, pe;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int phase_at(int p);
    if (hs_e < 0 || p < hs_e) return P_IDLE;
    if (ab_e >= 0 && p >= ab_e) return P_IDLE;
    if (ack_e >= 0 && p >= ack_e) return P_IDLE;
    if (cap_e >= 0 && p >= cap_e) return P_DONE;
    if (p >= hs_e + CLR) return P_RUN;
    return P_CLEAR;
  endfunction

  task automatic model_reset();
    hs_e = -1; ab_e = -1; cap_e = -1; ack_e = -1;
    m_pat = '0; m_rs = '0; m_conv = 1'b0; m_rc = 0; d1 = 1'b0; d2 = 1'b0;
  endtask

  task automatic model_step();
    int e, r, cnt, ph;
    logic synced;
    if (!rst_n) begin
      model_reset();
      return;
    end
    e = ecyc + 1;
    ph = phase_at(ecyc);
    r = hs_e + CLR;
    case (ph)
      P_IDLE: if (start_valid) begin
        hs_e = e; ab_e = -1; cap_e = -1; ack_e = -1; m_pat = s_in;
      end
      P_CLEAR: if (abort) ab_e = e;
      P_RUN: begin
        cnt = (ecyc - r > MAXC) ? MAXC : ecyc - r;
        synced = d2 && (e - 3 >= r);
        if (abort) ab_e = e;
        else if (synced || cnt == MAXC) begin
          cap_e = e; m_conv = synced; m_rc = cnt; m_rs = net_fullres;
        end
      end
      P_DONE: if (res_ready) ack_e = e;
      default: ;
    endcase
    d2 = d1;
    d1 = net_done;
    ecyc = e;
  endtask

  task automatic compare_all();
    int ph;
    ph = phase_at(ecyc);
    chk("start_ready", W'(start_ready), W'(ph == P_IDLE));
    chk("busy", W'(busy), W'(ph != P_IDLE));
    chk("net_en", W'(net_en), W'(ph == P_RUN));
    chk("net_rst_n", W'(net_rst_n), W'(ph == P_RUN || ph == P_DONE));
    chk("res_valid", W'(res_valid), W'(ph == P_DONE));
    chk("net_s", net_s, m_pat);
    chk("res_s", res_s, m_rs);
    chk("res_converged", W'(res_converged), W'(m_conv));
    chk("res_cycles", W'(res_cycles), W'(m_rc));
  endtask

  // Network stand-in: state drifts each enabled cycle, done raised on the done_at-th.
  task automatic drive_net();
    if (net_en) run_i++;
    else run_i = 0;
    net_fullres = net_s ^ {N{run_i[31:0]}};
    net_done = (done_at > 0) && (run_i >= done_at);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    drive_net();
  endtask

  task automatic start_run(input logic [W-1:0] p, input int d);
    s_in = p; done_at = d; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    for (int g = 0; g < budget && !res_valid; g++) tick();
    chk("res_valid_seen", W'(res_valid), W'(1));
  endtask

  task automatic ack();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    int k, en_cnt;
    start_valid = 1'b0; abort = 1'b0; res_ready = 1'b0; s_in = '0;
    net_fullres = '0; net_done = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) begin
      pa[i*SIZE +: SIZE] = 32'hA000_0000 + 32'(i);
      pb[i*SIZE +: SIZE] = 32'h0B0B_0000 + 32'(i * 3);
      pc[i*SIZE +: SIZE] = 32'hC3C3_0000 ^ 32'(i * 7);
      pd[i*SIZE +: SIZE] = 32'hD000_00F0 + 32'(i * 16);
      pe[i*SIZE +: SIZE] = 32'h5EED_0000 + 32'(i * 5);
    end
    #1 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_start_ready", W'(start_ready), W'(1));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_net_rst_n", W'(net_rst_n), W'(0));
    chk("rst_res_cycles", W'(res_cycles), W'(0));

    // Converged run: done 5 cycles into RUN.
    start_run(pa, 6);
    k = 0;
    while (net_rst_n == 1'b0 && k < 20) begin k++; tick(); end
    chk("clear_len", W'(k), W'(2));
    en_cnt = 0;
    for (int g = 0; g < 40 && !res_valid; g++) begin
      if (net_en) en_cnt++;
      tick();
    end
    chk("res_valid_seen", W'(res_valid), W'(1));
    chk("t1_run_cycles", W'(en_cnt), W'(8));
    chk("t1_res_cycles", W'(res_cycles), W'(7));
    chk("t1_conv", W'(res_converged), W'(1));
    chk("t1_res_s", res_s, pa ^ {N{32'd8}});
    ack();

    // Timeout run.
    start_run(pb, 0);
    wait_valid(60);
    chk("t2_res_cycles", W'(res_cycles), W'(20));
    chk("t2_conv", W'(res_converged), W'(0));
    chk("t2_res_s", res_s, pb ^ {N{32'd21}});

    // Result held back while a new probe waits.
    s_in = pc; done_at = 0; start_valid = 1'b1;
    repeat (10) tick();
    chk("t3_hold_valid", W'(res_valid), W'(1));
    chk("t3_hold_ready", W'(start_ready), W'(0));
    chk("t3_hold_res_s", res_s, pb ^ {N{32'd21}});
    ack();
    chk("t3_idle_ready", W'(start_ready), W'(1));
    tick();
    start_valid = 1'b0;
    chk("t3_accept_busy", W'(busy), W'(1));

    // Abort in the third RUN cycle.
    k = 0;
    for (int g = 0; g < 40 && k < 3; g++) begin
      if (net_en) k++;
      if (k < 3) tick();
    end
    chk("t4_reached_run", W'(k), W'(3));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_net_en", W'(net_en), W'(0));
    chk("t4_net_rst_n", W'(net_rst_n), W'(0));
    chk("t4_res_valid", W'(res_valid), W'(0));
    chk("t4_res_s", res_s, pb ^ {N{32'd21}});
    repeat (3) tick();
    chk("t4_still_idle", W'(busy), W'(0));

    // Done and timeout coincide.
    start_run(pd, 19);
    wait_valid(60);
    chk("t5_conv", W'(res_converged), W'(1));
    chk("t5_res_cycles", W'(res_cycles), W'(20));
    chk("t5_res_s", res_s, pd ^ {N{32'd21}});
    ack();

    // Asynchronous reset mid-RUN, then a normal recall.
    start_run(pe, 0);
    repeat (8) tick();
    chk("t6_in_run", W'(net_en), W'(1));
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_start_ready", W'(start_ready), W'(1));
    chk("t6_rst_busy", W'(busy), W'(0));
    chk("t6_rst_net_en", W'(net_en), W'(0));
    chk("t6_rst_net_rst_n", W'(net_rst_n), W'(0));
    chk("t6_rst_conv", W'(res_converged), W'(0));
    chk("t6_rst_res_s", res_s, '0);
    chk("t6_rst_net_s", net_s, '0);
    tick();
    rst_n = 1'b1;
    tick();
    start_run(pe, 3);
    wait_valid(40);
    chk("t6_conv", W'(res_converged), W'(1));
    chk("t6_res_cycles", W'(res_cycles), W'(4));
    chk("t6_res_s", res_s, pe ^ {N{32'd5}});
    ack();
    chk("t6_back_idle", W'(start_ready), W'(1));
    tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/hopfield_recall_ctrl.md
# hopfield_recall_ctrl

Sequencer for one recall on the N-neuron Hopfield network datapath. It accepts a probe pattern from the host with a valid/ready handshake and holds the network in reset for a fixed clear interval. It then enables the network and waits for its convergence flag, bounded by a cycle timeout, and returns the settled state with a converged/timeout status over a second valid/ready handshake. It sits between the host/config logic and the network instance; the weight bus is not touched by this block.

## Interface
- N, 9, number of neurons
- SIZE, 32, bits per neuron state word
- CLR_CYCLES, 2, cycles `net_rst_n` is held low before a run (≥1)
- MAX_CYCLES, 1000, RUN-cycle timeout (1 ≤ MAX_CYCLES < 2^CNT_W)
- CNT_W, 16, width of the cycle counter
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start_valid  in  1  host offers a probe pattern
- start_ready  out  1  controller can accept a probe
- s_in  in  SIZE*N  probe pattern
- abort  in  1  cancel current run
- net_en  out  1  network enable
- net_rst_n  out  1  network reset (active low)
- net_s  out  SIZE*N  initial state to the network
- net_fullres  in  SIZE*N  current network state
- net_done  in  1  network convergence flag (generated off a non-clk edge, treated as asynchronous)
- res_valid  out  1  result available
- res_ready  in  1  host takes result
- res_s  out  SIZE*N  captured final state
- res_converged  out  1  1 = converged, 0 = timed out
- res_cycles  out  CNT_W  RUN cycles consumed
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, CLEAR, RUN, DONE.
- IDLE: start_ready=1, net_rst_n=0, net_en=0. On start_valid&&start_ready: latch s_in into the pattern register, load the clear counter with CLR_CYCLES-1, go to CLEAR.
- CLEAR: net_rst_n=0, net_en=0. The clear counter decrements each cycle; at 0, go to RUN and set the cycle counter to 0.
- RUN: net_rst_n=1, net_en=1. The cycle counter increments each cycle, saturating at MAX_CYCLES. net_done passes through a 2-flop synchronizer; the synchronizer is held at 0 in IDLE and CLEAR.
  - If synced done=1: capture net_fullres→res_s, res_converged=1, res_cycles=counter. Go to DONE.
  - Else if counter==MAX_CYCLES: same capture with res_converged=0. Go to DONE.
  - If both hold in the same cycle, done wins (converged=1).
- DONE: res_valid=1, net_en=0, net_rst_n=1 (network state frozen). On res_ready, go to IDLE. res_s, res_converged and res_cycles hold until the next capture.
- net_s always drives the latched pattern register.
- abort in CLEAR or RUN: go to IDLE next cycle with no result, and the synchronizer clears. abort is ignored in IDLE and DONE.
- start_valid outside IDLE is not accepted. A new pattern is accepted no earlier than the cycle after the res_ready handshake.

## Timing
- Reset values:
  - state=IDLE, so start_ready=1 and busy=0.
  - net_en=0, net_rst_n=0, res_valid=0, res_converged=0.
  - res_s=0, res_cycles=0, pattern register=0, all counters 0.
- Start handshake at edge t: CLEAR occupies cycles t+1 … t+CLR_CYCLES. RUN starts at t+CLR_CYCLES+1 with net_en=1.
- Done latency: net_done rising before edge k is seen as synced done after edge k+1. The capture occurs at edge k+2, and res_valid=1 from then.
- Timeout: capture occurs in the RUN cycle where the counter reads MAX_CYCLES, so res_cycles=MAX_CYCLES.
- All outputs are registered; no combinational path from inputs to outputs.
- Asynchronous reset during any state returns to the reset values immediately, including net_rst_n=0.

## Test plan
- Reset, then start with s_in=pattern A. The network model asserts net_done 5 cycles after RUN entry. Required: net_rst_n low for exactly 2 cycles, res_valid 7 RUN cycles after entry, res_converged=1, res_cycles=7, res_s=model state.
- Model never asserts done, MAX_CYCLES=20 -> res_valid with res_converged=0, res_cycles=20, res_s=net_fullres at capture.
- Hold res_ready=0 for 10 cycles in DONE while start_valid=1 -> res_valid and res_s stable, start_ready=0. Then assert res_ready -> IDLE next cycle, new start accepted the cycle after.
- abort in the 3rd RUN cycle -> IDLE next cycle, net_en=0, net_rst_n=0, res_valid stays 0, previous res_s unchanged.
- net_done asserted in the same cycle the counter reaches MAX_CYCLES -> res_converged=1.
- rst_n pulsed low mid-RUN -> all outputs at reset values asynchronously, and a subsequent start completes normally.
